// File: rtl/fetch_prefetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_prefetch_stage_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction
endpackage

// File: rtl/fetch_prefetch_stage_if.sv
// Instruction-memory request/response port; fetch stage is master.
interface fetch_prefetch_stage_if;
    import fetch_prefetch_stage_pkg::*;

    logic               req_valid;
    logic [XLEN-1:0]    req_addr;
    logic               req_ready;
    logic               rsp_valid;
    logic [INSTR_W-1:0] rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_prefetch_stage_fifo.sv
// Small synchronous FIFO with clear; head is read combinationally.
module fetch_prefetch_stage_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/fetch_prefetch_stage.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, prefetch queue to decode.
module fetch_prefetch_stage
    import fetch_prefetch_stage_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fetch_prefetch_stage_if.master   imem,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic [XLEN-1:0]          flush_pc_i,
    output logic                     if_valid_o,
    output logic [INSTR_W-1:0]       if_instr_o,
    output logic [XLEN-1:0]          if_pc_o,
    output logic [XLEN-1:0]          if_pc_plus4_o
);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CRW = CW + 1;
    localparam int unsigned QW  = XLEN + INSTR_W;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   trk_count, q_count;
    logic [XLEN-1:0] trk_pc;
    logic [QW-1:0]   q_head;
    logic            trk_empty, q_empty;
    logic [CRW-1:0]  credits;
    logic            accept, rsp_keep, rsp_drop, pop;

    // Credits cover queued words, tracked requests and responses still owed from before a flush.
    assign credits = CRW'(q_count) + CRW'(trk_count) + CRW'(discard_q);

    assign imem.req_valid = rst_n && (credits < CRW'(DEPTH)) && !flush_i;
    assign imem.req_addr  = pc_q;
    assign accept         = imem.req_valid && imem.req_ready;

    // Older responses belong to flushed requests, so discards are consumed first.
    assign rsp_drop = imem.rsp_valid && (discard_q != '0);
    assign rsp_keep = imem.rsp_valid && (discard_q == '0) && !flush_i && !trk_empty;
    assign pop      = !q_empty && !stall_i && !flush_i;

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (flush_i) begin
            pc_d      = align_pc(flush_pc_i);
            discard_d = discard_q + trk_count - CW'(imem.rsp_valid);
        end else begin
            if (accept)   pc_d = pc_q + XLEN'(4);
            if (rsp_drop) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    fetch_prefetch_stage_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_req_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .pop_i   (rsp_keep),
        .clear_i (flush_i),
        .din_i   (pc_q),
        .dout_o  (trk_pc),
        .count_o (trk_count),
        .empty_o (trk_empty)
    );

    fetch_prefetch_stage_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_instr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rsp_keep),
        .pop_i   (pop),
        .clear_i (flush_i),
        .din_i   ({trk_pc, imem.rsp_data}),
        .dout_o  (q_head),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    assign if_valid_o    = !q_empty;
    assign if_instr_o    = q_empty ? NOP_INSTR : q_head[INSTR_W-1:0];
    assign if_pc_o       = q_empty ? '0 : q_head[QW-1 -: XLEN];
    assign if_pc_plus4_o = if_pc_o + XLEN'(4);
endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Bench for fetch_prefetch_stage: behavioural imem with fixed latency and an in-order PC scoreboard.
module tb_fetch_prefetch_stage;
    import fetch_prefetch_stage_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        stall = 0;
    logic        flush = 0;
    logic [31:0] flush_pc = '0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] req_exp;

    fetch_prefetch_stage_if imem_if ();

    fetch_prefetch_stage #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem_if),
        .stall_i       (stall),
        .flush_i       (flush),
        .flush_pc_i    (flush_pc),
        .if_valid_o    (if_valid),
        .if_instr_o    (if_instr),
        .if_pc_o       (if_pc),
        .if_pc_plus4_o (if_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_reset(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
        req_exp = start;
    endtask

    // Memory model: responses in order, mem_lat cycles after acceptance.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend.delete();
            imem_if.rsp_valid = 0;
            imem_if.rsp_data  = '0;
        end else begin
            cyc++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_if.rsp_valid = 1;
                imem_if.rsp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_if.rsp_valid = 0;
                imem_if.rsp_data  = '0;
            end
        end
    end

    // Monitor: request address order, no request during flush, decode-side scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) chk("flush_noreq", {31'b0, imem_if.req_valid}, 32'd0);
            if (imem_if.req_valid && imem_if.req_ready) begin
                chk("req_addr", imem_if.req_addr, req_exp);
                req_exp = req_exp + 32'd4;
                pend.push_back('{addr: imem_if.req_addr, due: cyc + mem_lat});
            end
            if (if_valid && !stall && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e);
                    chk("if_instr", if_instr, mem_word(e));
                    chk("if_pc_plus4", if_pc_plus4, e + 32'd4);
                end
            end
        end
    end

    task automatic start_reset();
        rst_n = 0;
        stall = 0;
        flush = 0;
        sb_reset(32'h0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        @(negedge clk);
        while (!if_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {31'b0, if_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, "_instr"}, if_instr, NOP_INSTR);
        chk({tag, "_pc"}, if_pc, 32'd0);
        chk({tag, "_pc4"}, if_pc_plus4, 32'd4);
        chk({tag, "_reqv"}, {31'b0, imem_if.req_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        imem_if.req_ready = 1;
        sb_reset(32'h0);

        // 1: streaming with 1-cycle memory
        start_reset();
        mem_lat = 1;
        #12 check_reset_outputs("rst");
        release_reset();
        @(negedge clk);
        chk("t1_c1_reqv", {31'b0, imem_if.req_valid}, 32'd1);
        chk("t1_c1_addr", imem_if.req_addr, 32'h0);
        chk("t1_c1_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        chk("t1_c2_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        chk("t1_c3_valid", {31'b0, if_valid}, 32'd1);
        chk("t1_c3_pc", if_pc, 32'h0);
        chk("t1_c3_pc4", if_pc_plus4, 32'h4);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t1_nogap", {31'b0, if_valid}, 32'd1);
        end

        // 2: decode stall fills the queue to DEPTH and freezes outputs
        @(posedge clk);
        #1 start_reset();
        stall = 1;
        release_reset();
        repeat (10) @(negedge clk);
        chk("t2_reqv", {31'b0, imem_if.req_valid}, 32'd0);
        chk("t2_valid", {31'b0, if_valid}, 32'd1);
        chk("t2_pc", if_pc, 32'h0);
        chk("t2_instr", if_instr, mem_word(32'h0));
        chk("t2_inflight", 32'(pend.size()), 32'd0);
        @(posedge clk);
        #1 stall = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_nogap", {31'b0, if_valid}, 32'd1);
        end

        // 3: flush with 3 requests in flight on a 3-cycle memory
        @(posedge clk);
        #1 start_reset();
        mem_lat = 3;
        release_reset();
        repeat (3) @(posedge clk);
        #1 flush = 1;
        flush_pc = 32'h103;
        sb_reset(32'h100);
        @(negedge clk);
        chk("t3_inflight", 32'(pend.size()), 32'd2);
        chk("t3_rsp_coinc", {31'b0, imem_if.rsp_valid}, 32'd1);
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        chk("t3_reqv", {31'b0, imem_if.req_valid}, 32'd1);
        chk("t3_addr", imem_if.req_addr, 32'h100);
        wait_valid(20);
        chk("t3_first_pc", if_pc, 32'h100);
        repeat (6) @(negedge clk);

        // 4: flush coincident with a response while decode is stalled
        @(posedge clk);
        #1 start_reset();
        mem_lat = 1;
        stall = 1;
        release_reset();
        repeat (2) @(posedge clk);
        #1 flush = 1;
        flush_pc = 32'h200;
        sb_reset(32'h200);
        @(negedge clk);
        chk("t4_head_valid", {31'b0, if_valid}, 32'd1);
        chk("t4_head_pc", if_pc, 32'h0);
        chk("t4_rsp_coinc", {31'b0, imem_if.rsp_valid}, 32'd1);
        @(posedge clk);
        #1 flush = 0;
        @(negedge clk);
        chk("t4_valid_after", {31'b0, if_valid}, 32'd0);
        chk("t4_instr_after", if_instr, NOP_INSTR);
        chk("t4_addr", imem_if.req_addr, 32'h200);
        wait_valid(20);
        chk("t4_first_pc", if_pc, 32'h200);
        @(posedge clk);
        #1 stall = 0;
        repeat (6) @(negedge clk);

        // 5: memory not ready holds the request stable
        @(posedge clk);
        #1 start_reset();
        imem_if.req_ready = 0;
        release_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", {31'b0, imem_if.req_valid}, 32'd1);
            chk("t5_hold_addr", imem_if.req_addr, 32'h0);
        end
        @(posedge clk);
        #1 imem_if.req_ready = 1;
        @(negedge clk);
        chk("t5_addr0", imem_if.req_addr, 32'h0);
        @(negedge clk);
        chk("t5_addr1", imem_if.req_addr, 32'h4);
        repeat (6) @(negedge clk);

        // 6: asynchronous reset mid-stream, then restart at RESET_PC
        @(posedge clk);
        #1 start_reset();
        mem_lat = 2;
        release_reset();
        repeat (7) @(negedge clk);
        chk("t6_running", {31'b0, if_valid}, 32'd1);
        @(posedge clk);
        #2 start_reset();
        #1 check_reset_outputs("t6_rst");
        release_reset();
        wait_valid(20);
        chk("t6_restart_pc", if_pc, 32'h0);
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
